// File: rtl/contador_cronometro.sv
// ---------------------------------------------------------------------------
// contador_cronometro
// Stopwatch counter with a MM:SS.CC display (max 59:59.99). It has a lap mode
// that freezes the display while the internal count keeps running.
//
// Parameters
//   DIV           clock cycles per centisecond tick (2 .. 2^20)
//
// Ports
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   iniciar_parar start/stop pulse (one cycle, synchronous)
//   zerar         clear pulse (one cycle, synchronous), highest priority
//   volta         lap pulse (one cycle, synchronous), ignored while stopped
//   cent_u/cent_d centiseconds BCD digits
//   seg_u/seg_d   seconds BCD digits
//   min_u/min_d   minutes BCD digits
//   rodando       high while the internal count advances
//   congelado     high while the display shows the lap snapshot
//   estouro       one-cycle pulse after wrapping 59:59.99 -> 00:00.00
// ---------------------------------------------------------------------------
module contador_cronometro #(
   parameter int DIV = 500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       iniciar_parar,
   input  logic       zerar,
   input  logic       volta,
   output logic [3:0] cent_u,
   output logic [3:0] cent_d,
   output logic [3:0] seg_u,
   output logic [3:0] seg_d,
   output logic [3:0] min_u,
   output logic [3:0] min_d,
   output logic       rodando,
   output logic       congelado,
   output logic       estouro
);

   localparam int            PW      = $clog2(DIV);
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

   typedef enum logic [1:0] {
      PARADO   = 2'd0,
      CONTANDO = 2'd1,
      VOLTA    = 2'd2
   } estado_t;

   estado_t       estado;
   logic [PW-1:0] pre;
   // Packed BCD count, {min_d, min_u, seg_d, seg_u, cent_d, cent_u}
   logic [23:0]   cnt;
   logic [23:0]   snap;
   logic [23:0]   cnt_inc;
   logic [23:0]   disp;
   logic          ativo;
   logic          tick;
   logic          wrap;

   assign ativo = (estado != PARADO);
   assign tick  = ativo && (pre == PRE_MAX);

   // One-centisecond BCD increment with the ripple carry chain. The
   // seconds-tens and minutes-tens digits roll over at 5.
   always_comb begin
      cnt_inc = cnt;
      wrap    = 1'b0;
      if (cnt[3:0] != 4'd9) begin
         cnt_inc[3:0] = cnt[3:0] + 4'd1;
      end else begin
         cnt_inc[3:0] = 4'd0;
         if (cnt[7:4] != 4'd9) begin
            cnt_inc[7:4] = cnt[7:4] + 4'd1;
         end else begin
            cnt_inc[7:4] = 4'd0;
            if (cnt[11:8] != 4'd9) begin
               cnt_inc[11:8] = cnt[11:8] + 4'd1;
            end else begin
               cnt_inc[11:8] = 4'd0;
               if (cnt[15:12] != 4'd5) begin
                  cnt_inc[15:12] = cnt[15:12] + 4'd1;
               end else begin
                  cnt_inc[15:12] = 4'd0;
                  if (cnt[19:16] != 4'd9) begin
                     cnt_inc[19:16] = cnt[19:16] + 4'd1;
                  end else begin
                     cnt_inc[19:16] = 4'd0;
                     if (cnt[23:20] != 4'd5) begin
                        cnt_inc[23:20] = cnt[23:20] + 4'd1;
                     end else begin
                        cnt_inc[23:20] = 4'd0;
                        wrap           = 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado    <= PARADO;
         pre       <= '0;
         cnt       <= '0;
         snap      <= '0;
         rodando   <= 1'b0;
         congelado <= 1'b0;
         estouro   <= 1'b0;
      end else if (zerar) begin
         estado    <= PARADO;
         pre       <= '0;
         cnt       <= '0;
         snap      <= '0;
         rodando   <= 1'b0;
         congelado <= 1'b0;
         estouro   <= 1'b0;
      end else begin
         // The prescaler is frozen while stopped so a restart keeps the
         // fraction of the centisecond already elapsed.
         if (ativo) begin
            pre <= tick ? '0 : pre + 1'b1;
         end
         // A tick on the stopping edge still counts.
         if (tick) begin
            cnt <= cnt_inc;
         end
         estouro <= tick & wrap;

         case (estado)
            PARADO: begin
               if (iniciar_parar) begin
                  estado    <= CONTANDO;
                  rodando   <= 1'b1;
                  congelado <= 1'b0;
               end
            end
            CONTANDO: begin
               if (iniciar_parar) begin
                  estado    <= PARADO;
                  rodando   <= 1'b0;
                  congelado <= 1'b0;
               end else if (volta) begin
                  // Snapshot takes the pre-edge count, not cnt_inc.
                  estado    <= VOLTA;
                  snap      <= cnt;
                  rodando   <= 1'b1;
                  congelado <= 1'b1;
               end
            end
            VOLTA: begin
               if (iniciar_parar) begin
                  estado    <= PARADO;
                  rodando   <= 1'b0;
                  congelado <= 1'b0;
               end else if (volta) begin
                  estado    <= CONTANDO;
                  rodando   <= 1'b1;
                  congelado <= 1'b0;
               end
            end
            default: begin
               estado    <= PARADO;
               rodando   <= 1'b0;
               congelado <= 1'b0;
            end
         endcase
      end
   end

   // Display selection is a mux of registers, so the digits follow the count
   // on the same edge and switch to or from the snapshot on the state edge.
   assign disp   = (estado == VOLTA) ? snap : cnt;
   assign cent_u = disp[3:0];
   assign cent_d = disp[7:4];
   assign seg_u  = disp[11:8];
   assign seg_d  = disp[15:12];
   assign min_u  = disp[19:16];
   assign min_d  = disp[23:20];

endmodule

// File: tb/tb_contador_cronometro.sv
// ---------------------------------------------------------------------------
// tb_contador_cronometro
// Bench for contador_cronometro with DIV=4. The reference keeps the count as
// an integer number of centiseconds and derives the digits by division.
// ---------------------------------------------------------------------------
module tb_contador_cronometro;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       iniciar_parar;
   logic       zerar;
   logic       volta;
   logic [3:0] cent_u, cent_d, seg_u, seg_d, min_u, min_d;
   logic       rodando, congelado, estouro;

   contador_cronometro #(.DIV(DIV)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .iniciar_parar (iniciar_parar),
      .zerar         (zerar),
      .volta         (volta),
      .cent_u        (cent_u),
      .cent_d        (cent_d),
      .seg_u         (seg_u),
      .seg_d         (seg_d),
      .min_u         (min_u),
      .min_d         (min_d),
      .rodando       (rodando),
      .congelado     (congelado),
      .estouro       (estouro)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   logic chk_en = 1'b0;
   logic preload_req = 1'b0;

   // Reference model: mode 0=stopped, 1=running, 2=lap.
   int   m_mode, m_cnt, m_snap, m_pre, m_old;
   logic m_est, m_run, m_tk;

   logic [23:0] dut_disp;
   assign dut_disp = {min_d, min_u, seg_d, seg_u, cent_d, cent_u};

   function automatic logic [23:0] bcd_of(input int v);
      logic [3:0] d [6];
      d[0] = 4'(v % 10);
      d[1] = 4'((v / 10) % 10);
      d[2] = 4'((v / 100) % 10);
      d[3] = 4'((v / 1000) % 6);
      d[4] = 4'((v / 6000) % 10);
      d[5] = 4'((v / 60000) % 6);
      return {d[5], d[4], d[3], d[2], d[1], d[0]};
   endfunction

   task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nome, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n or posedge preload_req) begin
      if (!rst_n) begin
         m_mode = 0; m_cnt = 0; m_snap = 0; m_pre = 0; m_est = 1'b0;
      end else if (preload_req) begin
         m_cnt = 359998;
      end else if (zerar) begin
         m_mode = 0; m_cnt = 0; m_snap = 0; m_pre = 0; m_est = 1'b0;
      end else begin
         m_old = m_cnt;
         m_run = (m_mode != 0);
         m_tk  = m_run && (m_pre == DIV - 1);
         if (m_run) m_pre = m_tk ? 0 : m_pre + 1;
         m_est = m_tk && (m_old == 359999);
         if (m_tk) m_cnt = (m_old + 1) % 360000;
         if (m_mode == 0) begin
            if (iniciar_parar) m_mode = 1;
         end else if (m_mode == 1) begin
            if (iniciar_parar) m_mode = 0;
            else if (volta) begin m_mode = 2; m_snap = m_old; end
         end else begin
            if (iniciar_parar) m_mode = 0;
            else if (volta) m_mode = 1;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("ciclo",
               {5'd0, dut_disp, rodando, congelado, estouro},
               {5'd0, bcd_of((m_mode == 2) ? m_snap : m_cnt),
                logic'(m_mode != 0), logic'(m_mode == 2), m_est});
      end
   end

   task automatic pulse(input logic ip, input logic z, input logic v);
      iniciar_parar = ip; zerar = z; volta = v;
      @(posedge clk); #1;
      iniciar_parar = 1'b0; zerar = 1'b0; volta = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      rst_n = 1'b0; iniciar_parar = 1'b0; zerar = 1'b0; volta = 1'b0;
      #1;
      check("reset_disp", {8'd0, dut_disp}, 32'h000000);
      check("reset_flags", {29'd0, rodando, congelado, estouro}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk_en = 1'b1;

      // 40 cycles of counting gives ten centiseconds
      pulse(1, 0, 0);
      idle(40);
      check("run40_disp", {8'd0, dut_disp}, 32'h000010);
      check("run40_rodando", {31'd0, rodando}, 32'd1);

      // Lap freeze and release
      pulse(0, 1, 0);
      pulse(1, 0, 0);
      idle(20);
      check("lap_pre", {8'd0, dut_disp}, 32'h000005);
      pulse(0, 0, 1);
      idle(20);
      check("lap_hold", {8'd0, dut_disp}, 32'h000005);
      check("lap_congelado", {31'd0, congelado}, 32'd1);
      pulse(0, 0, 1);
      check("lap_exit", {8'd0, dut_disp}, 32'h000010);
      check("lap_exit_cong", {31'd0, congelado}, 32'd0);

      // Stop mid-centisecond keeps the prescaler fraction
      pulse(0, 1, 0);
      pulse(1, 0, 0);
      idle(5);
      pulse(1, 0, 0);
      idle(3);
      check("stop_hold", {8'd0, dut_disp}, 32'h000001);
      check("stop_rodando", {31'd0, rodando}, 32'd0);
      pulse(1, 0, 0);
      idle(1);
      check("resume_1", {8'd0, dut_disp}, 32'h000001);
      idle(1);
      check("resume_2", {8'd0, dut_disp}, 32'h000002);

      // Volta ignored while stopped
      pulse(1, 0, 0);
      pulse(0, 0, 1);
      check("volta_parado", {30'd0, rodando, congelado}, 32'd0);

      // Wrap from 59:59.98
      pulse(0, 1, 0);
      force dut.cnt = 24'h595998;
      preload_req = 1'b1;
      #1;
      release dut.cnt;
      preload_req = 1'b0;
      pulse(1, 0, 0);
      idle(4);
      check("wrap_99", {8'd0, dut_disp}, 32'h595999);
      check("wrap_99_est", {31'd0, estouro}, 32'd0);
      idle(4);
      check("wrap_00", {8'd0, dut_disp}, 32'h000000);
      check("wrap_est_hi", {31'd0, estouro}, 32'd1);
      idle(1);
      check("wrap_est_lo", {31'd0, estouro}, 32'd0);

      // Clear wins over start and lap
      idle(7);
      pulse(1, 1, 1);
      check("zerar_prio_disp", {8'd0, dut_disp}, 32'h000000);
      check("zerar_prio_rod", {31'd0, rodando}, 32'd0);
      idle(6);
      check("zerar_prio_hold", {8'd0, dut_disp}, 32'h000000);

      // Asynchronous reset mid-count at 00:01.23
      pulse(1, 0, 0);
      idle(492);
      check("pre_rst_disp", {8'd0, dut_disp}, 32'h000123);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_disp", {8'd0, dut_disp}, 32'h000000);
      check("async_rst_flags", {29'd0, rodando, congelado, estouro}, 32'd0);
      #3 rst_n = 1'b1;
      idle(10);
      check("post_rst_idle", {8'd0, dut_disp}, 32'h000000);
      pulse(1, 0, 0);
      idle(4);
      check("post_rst_run", {8'd0, dut_disp}, 32'h000001);

      // Randomized control pulses
      pulse(0, 1, 0);
      for (int i = 0; i < 3000; i++) begin
         iniciar_parar = ($urandom_range(0, 19) == 0);
         volta         = ($urandom_range(0, 9) == 0);
         zerar         = ($urandom_range(0, 299) == 0);
         @(posedge clk); #1;
         iniciar_parar = 1'b0; volta = 1'b0; zerar = 1'b0;
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
